// File: rtl/pps_monitor_pkg.sv
// Shared types for the GPS 1PPS monitor.
//   pps_state_e : lock-tracking FSM states (2-bit encoding).
package pps_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no edge seen yet
    S_ACQ  = 2'd1,  // one reference edge seen, waiting for an in-window interval
    S_LOCK = 2'd2,  // intervals arriving inside the tolerance window
    S_LOST = 2'd3   // timed out while locked; next edge restarts acquisition
  } pps_state_e;

endpackage

// File: rtl/pps_monitor_edge_sync.sv
// Brings the asynchronous PPS input into the clk domain and flags its rising edges.
//   clk, rst : system clock, synchronous active-high reset
//   pps_in   : asynchronous 1PPS input
//   rise     : high for one cycle when the synchronised PPS goes 0 -> 1
module pps_edge_sync #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pps_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], pps_in};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule

// File: rtl/pps_monitor.sv
// GPS 1PPS conditioner: synchronises the PPS, measures the clk-cycle interval between
// edges, tracks lock inside a +/- tolerance window, counts timing faults and drives the LED.
//   clk, rst        : system clock, synchronous active-high reset
//   pps_in          : asynchronous GPS 1PPS input
//   clr_err         : strobe, clears pps_err_cnt (wins over a simultaneous fault)
//   pps_pulse_o     : 1-cycle pulse per PPS rising edge
//   pps_count       : last published interval in clk cycles
//   pps_count_valid : 1-cycle strobe, pps_count updated
//   pps_locked      : FSM is in S_LOCK
//   pps_err_cnt     : saturating fault counter
//   pps_led         : LED drive, lit for LED_PULSE_CYCLES after each locked edge
module pps_monitor
  import pps_monitor_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 100000000,
  parameter int unsigned PPS_TOL          = 100000,
  parameter int unsigned COUNT_WIDTH      = 32,
  parameter int unsigned ERR_WIDTH        = 16,
  parameter int unsigned SYNC_STAGES      = 3,
  parameter int unsigned LED_PULSE_CYCLES = 10000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pps_in,
  input  logic                   clr_err,
  output logic                   pps_pulse_o,
  output logic [COUNT_WIDTH-1:0] pps_count,
  output logic                   pps_count_valid,
  output logic                   pps_locked,
  output logic [ERR_WIDTH-1:0]   pps_err_cnt,
  output logic                   pps_led
);

  localparam int unsigned LED_W = $clog2(LED_PULSE_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] L_WIN_LO = COUNT_WIDTH'(CLK_FREQ_HZ - PPS_TOL);
  localparam logic [COUNT_WIDTH-1:0] L_WIN_HI = COUNT_WIDTH'(CLK_FREQ_HZ + PPS_TOL);

  logic                   w_rise;
  logic                   w_in_win;
  logic                   w_timeout;
  logic                   w_fault;
  logic                   w_publish;
  pps_state_e             w_next;

  pps_state_e             r_state;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [ERR_WIDTH-1:0]   r_err;
  logic [LED_W-1:0]       r_led_tmr;
  logic                   r_pulse;
  logic                   r_valid;
  logic [COUNT_WIDTH-1:0] r_count;

  pps_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .pps_in(pps_in),
    .rise  (w_rise)
  );

  assign w_in_win  = (r_cnt >= L_WIN_LO) && (r_cnt <= L_WIN_HI);
  // An edge landing exactly on the window limit is a valid interval, not a timeout.
  assign w_timeout = !w_rise && (r_cnt == L_WIN_HI);

  always_comb begin
    w_next    = r_state;
    w_fault   = 1'b0;
    w_publish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_next = S_ACQ;
      end
      S_ACQ: begin
        if (w_rise) begin
          w_publish = 1'b1;
          if (w_in_win) begin
            w_next = S_LOCK;
          end else begin
            w_fault = 1'b1;
          end
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_LOCK: begin
        if (w_rise) begin
          w_publish = 1'b1;
          if (!w_in_win) begin
            w_next  = S_ACQ;
            w_fault = 1'b1;
          end
        end else if (w_timeout) begin
          w_next  = S_LOST;
          w_fault = 1'b1;
        end
      end
      S_LOST: begin
        if (w_rise) w_next = S_ACQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_err     <= '0;
      r_led_tmr <= '0;
      r_pulse   <= 1'b0;
      r_valid   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      r_pulse <= w_rise;
      r_valid <= w_publish;

      if (w_publish) r_count <= r_cnt;

      if (w_rise) begin
        r_cnt <= COUNT_WIDTH'(1);
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + COUNT_WIDTH'(1);
      end

      if (clr_err) begin
        r_err <= '0;
      end else if (w_fault && (r_err != '1)) begin
        r_err <= r_err + ERR_WIDTH'(1);
      end

      // Locked edges (re)load the timer; any exit from S_LOCK darkens the LED at once.
      if (w_rise && (w_next == S_LOCK)) begin
        r_led_tmr <= LED_W'(LED_PULSE_CYCLES);
      end else if ((r_state == S_LOCK) && (w_next != S_LOCK)) begin
        r_led_tmr <= '0;
      end else if (r_led_tmr != '0) begin
        r_led_tmr <= r_led_tmr - LED_W'(1);
      end
    end
  end

  assign pps_pulse_o     = r_pulse;
  assign pps_count       = r_count;
  assign pps_count_valid = r_valid;
  assign pps_locked      = (r_state == S_LOCK);
  assign pps_err_cnt     = r_err;
  assign pps_led         = (r_led_tmr != '0);

endmodule

// File: tb/tb_pps_monitor.sv
// Scoreboard bench for pps_monitor: each driven PPS edge queues the response expected at its
// pulse; a negedge monitor pops and compares whenever pps_pulse_o appears.
module tb_pps_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pps_in = 1'b0;
  logic        clr_err = 1'b0;
  logic        pps_pulse_o;
  logic [31:0] pps_count;
  logic        pps_count_valid;
  logic        pps_locked;
  logic [1:0]  pps_err_cnt;
  logic        pps_led;

  typedef struct {
    int unsigned exp_cyc;
    logic        valid;
    logic [31:0] count;
    logic        locked;
    logic [31:0] err;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned led_run = 0;
  logic        led_prev = 1'b0;

  pps_monitor #(
    .CLK_FREQ_HZ     (1000),
    .PPS_TOL         (10),
    .COUNT_WIDTH     (32),
    .ERR_WIDTH       (2),
    .SYNC_STAGES     (3),
    .LED_PULSE_CYCLES(50)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pps_in         (pps_in),
    .clr_err        (clr_err),
    .pps_pulse_o    (pps_pulse_o),
    .pps_count      (pps_count),
    .pps_count_valid(pps_count_valid),
    .pps_locked     (pps_locked),
    .pps_err_cnt    (pps_err_cnt),
    .pps_led        (pps_led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Called at a negedge: queues the expected pulse response, raises pps_in for 100 cycles,
  // optionally strobes clr_err in the edge's rise cycle, and returns gap cycles after the rise.
  task automatic drive_edge(input logic v, input int unsigned c, input logic l,
                            input int unsigned e, input logic clr, input int unsigned gap);
    exp_t x;
    x.exp_cyc = cyc + 4;
    x.valid   = v;
    x.count   = c;
    x.locked  = l;
    x.err     = e;
    exp_q.push_back(x);
    pps_in = 1'b1;
    if (clr) begin
      repeat (3) @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      repeat (96) @(negedge clk);
    end else begin
      repeat (100) @(negedge clk);
    end
    pps_in = 1'b0;
    repeat (gap - 100) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse"},  32'(pps_pulse_o),     0);
    check({tag, "_count"},  pps_count,            0);
    check({tag, "_valid"},  32'(pps_count_valid), 0);
    check({tag, "_locked"}, 32'(pps_locked),      0);
    check({tag, "_err"},    32'(pps_err_cnt),     0);
    check({tag, "_led"},    32'(pps_led),         0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pps_count_valid) check("valid_implies_pulse", 32'(pps_pulse_o), 1);
    if (pps_pulse_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.exp_cyc);
        check("count_valid", 32'(pps_count_valid), 32'(e.valid));
        if (e.valid) check("count", pps_count, e.count);
        check("locked", 32'(pps_locked), 32'(e.locked));
        check("err_cnt", 32'(pps_err_cnt), e.err);
        check("led_at_pulse", 32'(pps_led), 32'(e.locked));
      end
    end
  end

  always @(negedge clk) begin
    if (pps_led) begin
      led_run++;
    end else begin
      if (led_prev) check("led_on_time", led_run, 50);
      led_run = 0;
    end
    led_prev = pps_led;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by cycle %0d expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Acquire and lock on nominal 1000-cycle intervals.
    drive_edge(1'b0, 0,    1'b0, 0, 1'b0, 1000);
    drive_edge(1'b1, 1000, 1'b1, 0, 1'b0, 1000);
    drive_edge(1'b1, 1000, 1'b1, 0, 1'b0, 989);
    // 989 is one below the window: fault, drop to ACQ; 990 (lower limit) relocks.
    drive_edge(1'b1, 989,  1'b0, 1, 1'b0, 990);
    drive_edge(1'b1, 990,  1'b1, 1, 1'b0, 1010);
    // Edge exactly on the timeout cycle stays locked; then pulses stop.
    drive_edge(1'b1, 1010, 1'b1, 1, 1'b0, 1013);
    check("pre_timeout_locked", 32'(pps_locked), 1);
    check("pre_timeout_err", 32'(pps_err_cnt), 1);
    @(negedge clk);
    check("timeout_locked", 32'(pps_locked), 0);
    check("timeout_err", 32'(pps_err_cnt), 2);
    check("timeout_led", 32'(pps_led), 0);
    repeat (300) @(negedge clk);
    // From S_LOST the next edge publishes nothing; one good interval relocks.
    drive_edge(1'b0, 0,    1'b0, 2, 1'b0, 1000);
    drive_edge(1'b1, 1000, 1'b1, 2, 1'b0, 500);
    // Short intervals: fault to 3, then saturate; clear coinciding with a fault wins.
    drive_edge(1'b1, 500,  1'b0, 3, 1'b0, 500);
    drive_edge(1'b1, 500,  1'b0, 3, 1'b0, 500);
    drive_edge(1'b1, 500,  1'b0, 3, 1'b0, 500);
    drive_edge(1'b1, 500,  1'b0, 0, 1'b1, 1000);
    drive_edge(1'b1, 1000, 1'b1, 0, 1'b0, 1000);
    drive_edge(1'b1, 1000, 1'b1, 0, 1'b0, 500);
    // Reset 500 cycles into a locked interval.
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (200) @(negedge clk);
    drive_edge(1'b0, 0,    1'b0, 0, 1'b0, 1000);
    drive_edge(1'b1, 1000, 1'b1, 0, 1'b0, 200);

    check("pending_pulses", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
